// File: rtl/spi_byte_engine_pkg.sv
// Shared types and constants for the SPI mode-0 byte engine.
package spi_pkg;

  localparam int SPI_BYTE_BITS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } spi_state_t;

  localparam logic [3:0] SPI_BITCNT_FULL = 4'd8;
  localparam logic [3:0] SPI_BITCNT_ZERO = 4'd0;

endpackage

// File: rtl/spi_byte_engine_if.sv
// Byte stream handshake between a producer (master) and the SPI byte engine (slave).
// With SPI_DREQ_GATE_EN defined the producer also supplies the decoder data-request line dreq.
interface spi_byte_engine_if;
  import spi_pkg::*;

  logic                     tx_valid;
  logic [SPI_BYTE_BITS-1:0] tx_data;
  logic                     tx_last;
  logic                     tx_ready;
  logic [SPI_BYTE_BITS-1:0] rx_data;
  logic                     rx_valid;
`ifdef SPI_DREQ_GATE_EN
  logic                     dreq;

  modport master (output tx_valid, tx_data, tx_last, dreq,
                  input  tx_ready, rx_data, rx_valid);
  modport slave  (input  tx_valid, tx_data, tx_last, dreq,
                  output tx_ready, rx_data, rx_valid);
`else
  modport master (output tx_valid, tx_data, tx_last,
                  input  tx_ready, rx_data, rx_valid);
  modport slave  (input  tx_valid, tx_data, tx_last,
                  output tx_ready, rx_data, rx_valid);
`endif
endinterface

// File: rtl/spi_byte_engine_edge_detect.sv
// Rise/fall pulse generator for the divided serial clock; sclk_i is already a clk-domain register.
module spi_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk_i,
  output logic rise_o,
  output logic fall_o
);

  logic sclk_q;

  // Previous-cycle copy of the divided clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
    end else begin
      sclk_q <= sclk_i;
    end
  end

  assign rise_o = sclk_i & ~sclk_q;
  assign fall_o = ~sclk_i & sclk_q;

endmodule

// File: rtl/spi_byte_engine.sv
// SPI mode-0 byte shifter driving an external clock divider; manages cs_n across multi-byte frames.
// Optional macro SPI_DREQ_GATE_EN gates tx_ready with the decoder dreq input.
module spi_byte_engine
  import spi_pkg::*;
#(
  parameter int CS_SETUP_CYCLES = 4,
  parameter int CS_HOLD_CYCLES  = 4,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  spi_byte_engine_if.slave    bus,
  output logic                div_en,
  input  logic                sclk_in,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  logic                spi_miso,
  output logic                spi_cs_n,
  output logic                busy
);

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  spi_state_t               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [3:0]               bitcnt_q, bitcnt_d;
  logic [SPI_BYTE_BITS-1:0] tx_sh_q, tx_sh_d;
  logic [SPI_BYTE_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [SPI_BYTE_BITS-1:0] rx_data_q, rx_data_d;
  logic                     last_q, last_d;
  logic                     rx_valid_q, rx_valid_d;
  logic                     div_en_q, div_en_d;
  logic                     mosi_q, mosi_d;
  logic                     cs_n_q, cs_n_d;
  logic                     busy_q, busy_d;
  logic                     rdy_q;
  logic                     rise_s, fall_s;
  logic                     ready_s, accept_s;

  spi_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .sclk_i (sclk_in),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // rdy_q keeps tx_ready low while reset is asserted and for the release cycle.
`ifdef SPI_DREQ_GATE_EN
  assign ready_s = (state_q == IDLE) & rdy_q & bus.dreq;
`else
  assign ready_s = (state_q == IDLE) & rdy_q;
`endif
  assign accept_s     = bus.tx_valid & ready_s;
  assign bus.tx_ready = ready_s;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign div_en       = div_en_q;
  assign spi_sclk     = sclk_in;
  assign spi_mosi     = mosi_q;
  assign spi_cs_n     = cs_n_q;
  assign busy         = busy_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_s) state_d = cs_n_q ? SETUP : SHIFT;
               else          state_d = IDLE;
      SETUP:   if (cnt_q == SETUP_LAST) state_d = SHIFT;
               else                     state_d = SETUP;
      SHIFT:   if (fall_s && (bitcnt_q == SPI_BITCNT_FULL)) state_d = DONE;
               else                                          state_d = SHIFT;
      DONE:    state_d = last_q ? HOLD : IDLE;
      HOLD:    if (cnt_q == HOLD_LAST) state_d = IDLE;
               else                    state_d = HOLD;
      default: state_d = IDLE;
    endcase
  end

  // FSM output / datapath next values; every output is registered below.
  always_comb begin
    cnt_d      = cnt_q;
    bitcnt_d   = bitcnt_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    rx_valid_d = 1'b0;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          tx_sh_d  = bus.tx_data;
          last_d   = bus.tx_last;
          mosi_d   = bus.tx_data[SPI_BYTE_BITS-1];
          bitcnt_d = SPI_BITCNT_ZERO;
          rx_sh_d  = {SPI_BYTE_BITS{1'b0}};
          cnt_d    = CNT_ZERO;
          cs_n_d   = 1'b0;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      SETUP: cnt_d = cnt_q + CNT_ONE;
      SHIFT: begin
        // A fall seen before any rise is divider start-up noise and is dropped.
        if (rise_s && (bitcnt_q != SPI_BITCNT_FULL)) begin
          rx_sh_d  = {rx_sh_q[SPI_BYTE_BITS-2:0], spi_miso};
          bitcnt_d = bitcnt_q + 4'd1;
        end else if (fall_s && (bitcnt_q == SPI_BITCNT_FULL)) begin
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          cnt_d      = CNT_ZERO;
        end else if (fall_s && (bitcnt_q != SPI_BITCNT_ZERO)) begin
          tx_sh_d = {tx_sh_q[SPI_BYTE_BITS-2:0], 1'b0};
          mosi_d  = tx_sh_q[SPI_BYTE_BITS-2];
        end else begin
          cnt_d = cnt_q;
        end
      end
      DONE: cnt_d = CNT_ZERO;
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cs_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = CNT_ZERO;
    endcase
    div_en_d = (state_d == SHIFT);
    busy_d   = (state_d != IDLE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= CNT_ZERO;
      bitcnt_q   <= SPI_BITCNT_ZERO;
      tx_sh_q    <= {SPI_BYTE_BITS{1'b0}};
      rx_sh_q    <= {SPI_BYTE_BITS{1'b0}};
      rx_data_q  <= {SPI_BYTE_BITS{1'b0}};
      last_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      div_en_q   <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bitcnt_q   <= bitcnt_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      rx_valid_q <= rx_valid_d;
      div_en_q   <= div_en_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      busy_q     <= busy_d;
      rdy_q      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed self-checking bench for spi_byte_engine with a behavioural count-based clock divider.
module tb_spi_byte_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_byte_engine_if bus_if ();

  logic div_en, sclk_in, spi_sclk, spi_mosi, spi_miso, spi_cs_n, busy;
  logic [7:0] clk_count = 8'd3;
  logic       miso_tie  = 1'b0;

  assign spi_miso = miso_tie ? 1'b1 : spi_mosi;

  spi_byte_engine #(
    .CS_SETUP_CYCLES (4),
    .CS_HOLD_CYCLES  (4),
    .CNT_W           (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if),
    .div_en   (div_en),
    .sclk_in  (sclk_in),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .busy     (busy)
  );

  // Divider: toggles every clk_count+1 cycles while enabled, output forced low otherwise.
  logic [7:0] dcnt;
  logic       dq;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt <= 8'd0;
      dq   <= 1'b0;
    end else if (!div_en) begin
      dcnt <= 8'd0;
      dq   <= 1'b0;
    end else if (dcnt == clk_count) begin
      dcnt <= 8'd0;
      dq   <= ~dq;
    end else begin
      dcnt <= dcnt + 8'd1;
    end
  end
  assign sclk_in = div_en & dq;

  // Pin monitor, sampled on the inactive edge.
  int          cyc = 0, rises = 0, falls = 0, rxv_cnt = 0, cs_rises = 0;
  int          cs_fall_cyc = 0, first_rise_cyc = 0, last_fall_cyc = 0, cs_rise_cyc = 0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1, got_rise = 1'b0;
  logic [15:0] mosi_bits = 16'h0000;
  logic [7:0]  rx_last = 8'h00;
  always @(negedge clk) begin
    cyc       <= cyc + 1;
    sclk_prev <= spi_sclk;
    cs_prev   <= spi_cs_n;
    if (spi_sclk && !sclk_prev) begin
      rises     <= rises + 1;
      mosi_bits <= {mosi_bits[14:0], spi_mosi};
      if (!got_rise) first_rise_cyc <= cyc;
      got_rise <= 1'b1;
    end
    if (!spi_sclk && sclk_prev) begin
      falls         <= falls + 1;
      last_fall_cyc <= cyc;
    end
    if (!spi_cs_n && cs_prev) begin
      cs_fall_cyc <= cyc;
      got_rise    <= 1'b0;
    end
    if (spi_cs_n && !cs_prev) begin
      cs_rise_cyc <= cyc;
      cs_rises    <= cs_rises + 1;
    end
    if (bus_if.rx_valid) begin
      rxv_cnt <= rxv_cnt + 1;
      rx_last <= bus_if.rx_data;
    end
  end

  int checks = 0, failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] data, input logic last);
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus_if.tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("send_ready", 32'(ok), 32'd1);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = data;
    bus_if.tx_last  = last;
    @(posedge clk);
    #1;
    bus_if.tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    logic ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check_eq("idle_timeout", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    #1;
  endtask

  int r0, f0, v0, c0;

  initial begin
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = 8'h00;
    bus_if.tx_last  = 1'b0;
`ifdef SPI_DREQ_GATE_EN
    bus_if.dreq = 1'b1;
`endif
    repeat (3) @(negedge clk);
    check_eq("rst_tx_ready", 32'(bus_if.tx_ready), 32'd0);
    check_eq("rst_cs_n",     32'(spi_cs_n),        32'd1);
    check_eq("rst_div_en",   32'(div_en),          32'd0);
    check_eq("rst_mosi",     32'(spi_mosi),        32'd0);
    check_eq("rst_busy",     32'(busy),            32'd0);
    check_eq("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check_eq("rst_rx_data",  32'(bus_if.rx_data),  32'h00);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_tx_ready", 32'(bus_if.tx_ready), 32'd1);

    // A5 looped back, single last byte, divider count 3.
    r0 = rises; f0 = falls; v0 = rxv_cnt; c0 = cs_rises;
    send(8'hA5, 1'b1);
    wait_idle();
    check_eq("a5_rx_data", 32'(rx_last), 32'hA5);
    check_eq("a5_rx_pulses", 32'(rxv_cnt - v0), 32'd1);
    check_eq("a5_rises", 32'(rises - r0), 32'd8);
    check_eq("a5_falls", 32'(falls - f0), 32'd8);
    check_eq("a5_mosi_bits", 32'(mosi_bits[7:0]), 32'hA5);
    check_eq("a5_cs_setup", 32'((first_rise_cyc - cs_fall_cyc) >= 4), 32'd1);
    check_eq("a5_cs_hold", 32'((cs_rise_cyc - last_fall_cyc) >= 4), 32'd1);
    check_eq("a5_cs_high", 32'(spi_cs_n), 32'd1);
    check_eq("a5_cs_rises", 32'(cs_rises - c0), 32'd1);

    // 3C (not last) then F0 (last), MISO tied high.
    miso_tie = 1'b1;
    r0 = rises; v0 = rxv_cnt; c0 = cs_rises;
    send(8'h3C, 1'b0);
    wait_idle();
    check_eq("3c_rx_data", 32'(rx_last), 32'hFF);
    check_eq("3c_cs_low", 32'(spi_cs_n), 32'd0);
    send(8'hF0, 1'b1);
    wait_idle();
    check_eq("f0_rx_data", 32'(rx_last), 32'hFF);
    check_eq("pair_rx_pulses", 32'(rxv_cnt - v0), 32'd2);
    check_eq("pair_rises", 32'(rises - r0), 32'd16);
    check_eq("pair_mosi_bits", 32'(mosi_bits), 32'h3CF0);
    check_eq("pair_cs_rises", 32'(cs_rises - c0), 32'd1);
    miso_tie = 1'b0;

    // Request of 11 during a byte must be ignored.
    r0 = rises; v0 = rxv_cnt;
    send(8'h66, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if ((rises - r0) >= 3) break;
    end
    check_eq("mid_tx_ready", 32'(bus_if.tx_ready), 32'd0);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = 8'h11;
    bus_if.tx_last  = 1'b1;
    repeat (5) @(negedge clk);
    bus_if.tx_valid = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);
    #1;
    check_eq("mid_rx_data", 32'(rx_last), 32'h66);
    check_eq("mid_mosi_bits", 32'(mosi_bits[7:0]), 32'h66);
    check_eq("mid_rises", 32'(rises - r0), 32'd8);
    check_eq("mid_rx_pulses", 32'(rxv_cnt - v0), 32'd1);
    check_eq("mid_busy", 32'(busy), 32'd0);

    // Reset after the 4th rise discards the byte.
    v0 = rxv_cnt; r0 = rises;
    send(8'hC3, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if ((rises - r0) >= 4) break;
    end
    rst_n = 1'b0;
    #1;
    check_eq("arst_cs_n", 32'(spi_cs_n), 32'd1);
    check_eq("arst_div_en", 32'(div_en), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_eq("arst_no_rx", 32'(rxv_cnt - v0), 32'd0);
    check_eq("arst_rx_data", 32'(bus_if.rx_data), 32'h00);
    r0 = rises; v0 = rxv_cnt;
    send(8'h5A, 1'b1);
    wait_idle();
    check_eq("5a_rx_data", 32'(rx_last), 32'h5A);
    check_eq("5a_rx_pulses", 32'(rxv_cnt - v0), 32'd1);
    check_eq("5a_rises", 32'(rises - r0), 32'd8);

    // Fastest divider setting.
    clk_count = 8'd0;
    r0 = rises; f0 = falls; v0 = rxv_cnt;
    send(8'h81, 1'b1);
    wait_idle();
    check_eq("81_rx_data", 32'(rx_last), 32'h81);
    check_eq("81_rises", 32'(rises - r0), 32'd8);
    check_eq("81_falls", 32'(falls - f0), 32'd8);
    check_eq("81_mosi_bits", 32'(mosi_bits[7:0]), 32'h81);
    check_eq("81_rx_pulses", 32'(rxv_cnt - v0), 32'd1);

`ifdef SPI_DREQ_GATE_EN
    clk_count = 8'd3;
    bus_if.dreq     = 1'b0;
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = 8'h77;
    bus_if.tx_last  = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("dreq_blocked_busy", 32'(busy), 32'd0);
    check_eq("dreq_blocked_ready", 32'(bus_if.tx_ready), 32'd0);
    bus_if.dreq = 1'b1;
    @(posedge clk);
    #1;
    bus_if.tx_valid = 1'b0;
    check_eq("dreq_start", 32'(busy), 32'd1);
    wait_idle();
    check_eq("dreq_rx_data", 32'(rx_last), 32'h77);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
